// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the n-bit shift register slice.
//   shift_mode_e    : operation select carried on the 2-bit mode port
//   MIN/MAX_WIDTH   : supported register width range
//   mode_is_shift() : true for the two modes that move bits (SHL / SHR)
//   count_width()   : width of a counter that can hold the value 0..width
// ---------------------------------------------------------------------------
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_LOAD = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_SHR  = 2'b11
   } shift_mode_e;

   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 64;

   // SHL and SHR share the same encoding prefix (mode[1] = 1).
   function automatic logic mode_is_shift(input shift_mode_e m);
      return (m == MODE_SHL) || (m == MODE_SHR);
   endfunction

   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : shift_pkg

// File: rtl/shift_counter.sv
// ---------------------------------------------------------------------------
// shift_counter
// Saturating count of shift/rotate edges since the last load or reset.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears the count
//   clr    in   synchronous clear (parallel load happened)
//   step   in   one shift or rotate happened on this edge
//   count  out  number of shifts, saturates at WIDTH
//   done   out  high while count == WIDTH (decoded, no extra latency)
// ---------------------------------------------------------------------------
module shift_counter
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr,
   input  logic                         step,
   output logic [$clog2(WIDTH+1)-1:0]   count,
   output logic                         done
);

   localparam int CW = count_width(WIDTH);
   localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // Clear has priority; the two are never requested together by the
   // top level, but the ordering keeps the behaviour well defined.
   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (step && (count_reg != COUNT_MAX)) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;
   assign done  = (count_reg == COUNT_MAX);

endmodule : shift_counter

// File: rtl/shift_register_nbit.sv
// ---------------------------------------------------------------------------
// shift_register_nbit
// Universal n-bit register: hold, parallel load, shift/rotate left/right,
// with a registered serial-out bit and a saturating shift counter.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   en     in   clock enable; when low every register holds
//   mode   in   00 HOLD, 01 LOAD, 10 SHL, 11 SHR (see shift_mode_e)
//   rot    in   SHL/SHR only: 1 rotate, 0 shift with sin as fill bit
//   sin    in   serial input bit
//   d      in   parallel load data
//   q      out  register contents
//   qbar   out  bitwise complement of q
//   sout   out  bit pushed out by the most recent shift/rotate
//   count  out  shifts since last load or reset, saturating at WIDTH
//   done   out  count == WIDTH
// ---------------------------------------------------------------------------
module shift_register_nbit
   import shift_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic                         rot,
   input  logic                         sin,
   input  logic [WIDTH-1:0]             d,
   output logic [WIDTH-1:0]             q,
   output logic [WIDTH-1:0]             qbar,
   output logic                         sout,
   output logic [$clog2(WIDTH+1)-1:0]   count,
   output logic                         done
);

   shift_mode_e      mode_e;
   logic             load_en;
   logic             shift_en;

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic             sout_reg;
   logic             sout_next;

   assign mode_e   = shift_mode_e'(mode);
   assign load_en  = en && (mode_e == MODE_LOAD);
   assign shift_en = en && mode_is_shift(mode_e);

   // Next-state for the data path. The fill bit is the serial input for
   // a plain shift, or the bit leaving the other end for a rotate; rot is
   // only consulted inside the shift branches so HOLD/LOAD ignore it.
   always_comb begin
      q_next    = q_reg;
      sout_next = sout_reg;
      if (en) begin
         unique case (mode_e)
            MODE_LOAD: begin
               q_next = d;
            end
            MODE_SHL: begin
               q_next    = {q_reg[WIDTH-2:0], (rot ? q_reg[WIDTH-1] : sin)};
               sout_next = q_reg[WIDTH-1];
            end
            MODE_SHR: begin
               q_next    = {(rot ? q_reg[0] : sin), q_reg[WIDTH-1:1]};
               sout_next = q_reg[0];
            end
            default: begin
               q_next    = q_reg;
               sout_next = sout_reg;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg    <= RESET_VALUE;
         sout_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         sout_reg <= sout_next;
      end
   end

   assign q    = q_reg;
   assign sout = sout_reg;

   // qbar is derived only from the register, so it moves with q on the
   // clock edge (or on reset) and never directly from d/sin/mode.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_qbar
         assign qbar[gi] = ~q_reg[gi];
      end
   endgenerate

   shift_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (load_en),
      .step  (shift_en),
      .count (count),
      .done  (done)
   );

endmodule : shift_register_nbit

// File: tb/tb_shift_register_nbit.sv
module tb_shift_register_nbit;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       rot = 1'b0;
   logic       sin = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] q;
   logic [7:0] qbar;
   logic       sout;
   logic [3:0] count;
   logic       done;

   int total = 0;
   int bad   = 0;
   int txn   = 0;
   logic cmp_on = 1'b0;

   always #5 clk = ~clk;

   shift_register_nbit #(
      .WIDTH       (W),
      .RESET_VALUE (RV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .mode  (mode),
      .rot   (rot),
      .sin   (sin),
      .d     (d),
      .q     (q),
      .qbar  (qbar),
      .sout  (sout),
      .count (count),
      .done  (done)
   );

   // Reference model: register value kept as an integer, shifts done with
   // multiply/divide, the counter as a clamped integer.
   int   m_q = 0;
   logic m_sout = 1'b0;
   int   m_cnt = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q    <= int'(RV);
         m_sout <= 1'b0;
         m_cnt  <= 0;
      end else if (en) begin
         if (mode == 2'b01) begin
            m_q   <= int'(d);
            m_cnt <= 0;
         end else if (mode == 2'b10) begin
            m_sout <= (m_q >= 128);
            m_q    <= (m_q * 2) % 256 + (rot ? ((m_q >= 128) ? 1 : 0) : int'(sin));
            m_cnt  <= (m_cnt < W) ? m_cnt + 1 : W;
         end else if (mode == 2'b11) begin
            m_sout <= (m_q % 2 == 1);
            m_q    <= m_q / 2 + (rot ? ((m_q % 2) * 128) : int'(sin) * 128);
            m_cnt  <= (m_cnt < W) ? m_cnt + 1 : W;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("q",     64'(q),     64'(m_q));
         chk("qbar",  64'(qbar),  64'(255 - m_q));
         chk("sout",  64'(sout),  64'(m_sout));
         chk("count", 64'(count), 64'(m_cnt));
         chk("done",  64'(done),  64'(m_cnt == W));
      end
   end

   task automatic cyc(input logic e, input logic [1:0] m, input logic r,
                      input logic s, input logic [7:0] dd, input logic rs);
      @(negedge clk);
      #1;
      en = e; mode = m; rot = r; sin = s; d = dd; reset = rs;
      @(posedge clk);
      #1;
      txn++;
      $display("txn %0d en=%b mode=%b rot=%b sin=%b d=%h rst=%b -> q=%h sout=%b cnt=%0d done=%b",
               txn, e, m, r, s, dd, rs, q, sout, count, done);
   endtask

   initial begin
      #1 reset = 1'b1;
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);
      cmp_on = 1'b1;
      chk("rst_q", 64'(q), 64'h A5);
      chk("rst_qbar", 64'(qbar), 64'h5A);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);

      // Mid-cycle asynchronous reset, observed before the next clock edge.
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 8'h3C, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_q", 64'(q), 64'hA5);
      chk("async_qbar", 64'(qbar), 64'h5A);
      chk("async_count", 64'(count), 64'd0);
      chk("async_done", 64'(done), 64'd0);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);

      // Load then shift left with zero fill.
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 8'h81, 1'b0);
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("shl_q", 64'(q), 64'h02);
      chk("shl_sout", 64'(sout), 64'd1);
      chk("shl_count", 64'(count), 64'd1);

      // Rotate right.
      cyc(1'b1, 2'b01, 1'b1, 1'b0, 8'h01, 1'b0);
      cyc(1'b1, 2'b11, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("ror_q", 64'(q), 64'h80);
      chk("ror_sout", 64'(sout), 64'd1);

      // Serial fill to saturation and beyond.
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("fill_q", 64'(q), 64'hFF);
      chk("fill_count", 64'(count), 64'd8);
      chk("fill_done", 64'(done), 64'd1);
      cyc(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("sat_count", 64'(count), 64'd8);
      chk("sat_done", 64'(done), 64'd1);

      // Hold: enable low with a shift mode, then enable high with HOLD.
      for (int i = 0; i < 3; i++) cyc(1'b0, 2'b10, 1'b1, 1'b0, 8'h55, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 1'b1, 1'b0, 8'h55, 1'b0);
      chk("hold_q", 64'(q), 64'hFF);
      chk("hold_sout", 64'(sout), 64'd1);
      chk("hold_count", 64'(count), 64'd8);

      // Reset in the middle of a shift sequence.
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
      chk("mid_count5", 64'(count), 64'd5);
      cyc(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b1);
      chk("mid_count", 64'(count), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 8'h12, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("mid_done_after", 64'(done), 64'd1);
      chk("mid_q_after", 64'(q), 64'h00);

      // Randomized traffic checked by the every-cycle compare.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), ($urandom_range(0, 39) == 0));
      end
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_shift_register_nbit

// File: doc/shift_register_nbit.md
SHIFT_REGISTER_NBIT -- requirements
Module: shift_register_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  when low, every register holds.
REQ-006 SHALL have port mode  input  2  operation: 00 HOLD, 01 LOAD, 10 SHL, 11 SHR.
REQ-007 SHALL have port rot  input  1  in SHL/SHR, 1 = rotate, 0 = shift with sin fill.
REQ-008 SHALL have port sin  input  1  serial input bit.
REQ-009 SHALL have port d  input  WIDTH  parallel load data.
REQ-010 SHALL have port q  output  WIDTH  register contents.
REQ-011 SHALL have port qbar  output  WIDTH  bitwise complement of q, always.
REQ-012 SHALL have port sout  output  1  registered copy of the bit shifted or rotated out on the last shift.
REQ-013 SHALL have port count  output  $clog2(WIDTH+1)  shifts since the last load or reset, saturating.
REQ-014 SHALL have port done  output  1  high while count == WIDTH.

Function
REQ-015 On a rising edge with en=1 and mode=LOAD, q SHALL take d, count SHALL become 0 and sout SHALL hold.
REQ-016 With en=1 and mode=SHL, q SHALL become {q[WIDTH-2:0], fill} and sout SHALL take the old q[WIDTH-1]; fill is sin if rot=0, else the old q[WIDTH-1].
REQ-017 With en=1 and mode=SHR, q SHALL become {fill, q[WIDTH-1:1]} and sout SHALL take the old q[0]; fill is sin if rot=0, else the old q[0].
REQ-018 HOLD mode, or en=0, SHALL leave q, sout and count unchanged.
REQ-019 Each SHL or SHR edge SHALL increment count by 1, saturating at WIDTH; once saturated it SHALL not wrap.
REQ-020 done SHALL be decoded combinationally from count, with no extra cycle of latency.
REQ-021 q, qbar and sout SHALL change only on the clock edge; there is no combinational path from d, sin or mode to any output.
REQ-022 The rot input SHALL be ignored in HOLD and LOAD modes.

Reset
REQ-023 Asserting reset SHALL set q=RESET_VALUE, qbar=~RESET_VALUE, sout=0, count=0 and done=0 immediately, independent of clk.
REQ-024 Reset asserted in the middle of a shift sequence SHALL abort the sequence; count restarts from 0 after release.
REQ-025 On the first rising edge after reset deasserts, the block SHALL operate normally.

Structure
REQ-026 The mode encoding (HOLD/LOAD/SHL/SHR) SHALL be defined as a typedef enum in the shared package shift_pkg.
REQ-027 The saturating shift counter, with its count and done outputs, SHALL be a sub-module named shift_counter, parametrised by WIDTH.

Verification
REQ-028 Reset test: WIDTH=8, RESET_VALUE=8'hA5, pulse reset mid-cycle -> q=A5, qbar=5A, count=0, done=0 before the next clk edge.
REQ-029 Load-then-shift-left test: LOAD d=8'h81, then SHL with rot=0, sin=0 -> q=02, sout=1, count=1.
REQ-030 Rotate-right test: q=8'h01, SHR with rot=1 -> q=80, sout=1.
REQ-031 Serial fill test: after LOAD, 8 SHL edges with sin=1 -> q=FF, count=8, done=1; a 9th SHL -> count stays 8.
REQ-032 Hold test: en=0 with mode=SHL, or en=1 with mode=HOLD, over 3 cycles -> q, sout and count unchanged.
REQ-033 Mid-sequence reset test: reset asserted after 5 shifts -> count=0, done=0; LOAD then 8 shifts -> done=1.
